scaler_frame_ctrl: RTL and testbench

//  Per-frame sequencer for the video scaler + input FIFO path on clk_hdmi. On each vsync rising

---
 rtl/scaler_pkg.sv | 20 ++
 rtl/scaler_frame_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_scaler_frame_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scaler_pkg.sv
// Shared definitions for the scaler frame sequencer: FSM encoding and default geometry.
package scaler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FIFO_RST = 2'd1,
        ST_SETTLE   = 2'd2,
        ST_RUN      = 2'd3
    } state_e;

    localparam int unsigned DEF_X_RES_WIDTH   = 11;
    localparam int unsigned DEF_Y_RES_WIDTH   = 11;
    localparam int unsigned DEF_RST_CYCLES    = 4;
    localparam int unsigned DEF_SETTLE_CYCLES = 1964;
    localparam int unsigned DEF_TIMEOUT_WIDTH = 24;

    // Shadow resolution fields reset to all-ones; nearest-neighbour is the reset mode.
    localparam logic DEF_NEAREST = 1'b1;

endpackage

// File: rtl/scaler_frame_ctrl.sv
// Per-frame sequencer for the scaler and its input FIFO: FIFO reset, settle, scaler start,
// output pixel counting, overrun/timeout detection and shadowed output configuration.
module scaler_frame_ctrl
    import scaler_pkg::*;
#(
    parameter int unsigned OUTPUT_X_RES_WIDTH = DEF_X_RES_WIDTH,
    parameter int unsigned OUTPUT_Y_RES_WIDTH = DEF_Y_RES_WIDTH,
    parameter int unsigned RST_CYCLES         = DEF_RST_CYCLES,
    parameter int unsigned SETTLE_CYCLES      = DEF_SETTLE_CYCLES,
    parameter int unsigned TIMEOUT_WIDTH      = DEF_TIMEOUT_WIDTH
) (
    input  logic                          clk_hdmi,
    input  logic                          rst_n,
    input  logic                          vsync_in,
    input  logic                          cfg_enable,
    input  logic [OUTPUT_X_RES_WIDTH-1:0] cfg_x_res,
    input  logic [OUTPUT_Y_RES_WIDTH-1:0] cfg_y_res,
    input  logic                          cfg_mode,
    input  logic                          dout_valid,
    input  logic                          err_clr,
    output logic                          fifo_rst,
    output logic                          scaler_start,
    output logic [OUTPUT_X_RES_WIDTH-1:0] out_x_res,
    output logic [OUTPUT_Y_RES_WIDTH-1:0] out_y_res,
    output logic                          out_nearest,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          err_overrun,
    output logic                          err_timeout,
    output logic [15:0]                   frame_cnt
);

    localparam int unsigned XW      = OUTPUT_X_RES_WIDTH;
    localparam int unsigned YW      = OUTPUT_Y_RES_WIDTH;
    localparam int unsigned AREA_W  = XW + YW;
    localparam int unsigned WD_W    = TIMEOUT_WIDTH;
    localparam int unsigned CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [AREA_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [AREA_W-1:0]   area_q, area_d;
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic                vsync_dly_q;
    logic [XW-1:0]       out_x_res_q, out_x_res_d;
    logic [YW-1:0]       out_y_res_q, out_y_res_d;
    logic                out_nearest_q, out_nearest_d;
    logic                fifo_rst_q, fifo_rst_d;
    logic                scaler_start_q, scaler_start_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                err_overrun_q, err_overrun_d;
    logic                err_timeout_q, err_timeout_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic                vs_edge;
    logic                start_ok;
    logic                latch;
    logic                done;
    logic                overrun_set;
    logic                timeout_set;
    logic                last_pix;
    logic [WD_W-1:0]     wd_inc;

    assign vs_edge  = vsync_in & ~vsync_dly_q;
    assign start_ok = vs_edge & cfg_enable & (|cfg_x_res) & (|cfg_y_res);
    assign last_pix = dout_valid & ((pix_cnt_q + AREA_W'(1)) == area_q);
    assign wd_inc   = wd_cnt_q + WD_W'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pix_cnt_d      = pix_cnt_q;
        area_d         = area_q;
        wd_cnt_d       = wd_cnt_q;
        out_x_res_d    = out_x_res_q;
        out_y_res_d    = out_y_res_q;
        out_nearest_d  = out_nearest_q;
        scaler_start_d = 1'b0;
        latch          = 1'b0;
        done           = 1'b0;
        overrun_set    = 1'b0;
        timeout_set    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    latch   = 1'b1;
                    state_d = ST_FIFO_RST;
                end
            end
            ST_FIFO_RST: begin
                // Frame sync edges are ignored while the FIFO is held in reset.
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (vs_edge) begin
                    overrun_set = 1'b1;
                    latch       = start_ok;
                    state_d     = start_ok ? ST_FIFO_RST : ST_IDLE;
                end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d          = '0;
                    scaler_start_d = 1'b1;
                    state_d        = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                wd_cnt_d = wd_inc;
                if (dout_valid) begin
                    pix_cnt_d = pix_cnt_q + AREA_W'(1);
                end
                // Completion wins over a coincident sync edge, which then opens the next frame.
                if (last_pix) begin
                    done    = 1'b1;
                    latch   = start_ok;
                    state_d = start_ok ? ST_FIFO_RST : ST_IDLE;
                end else if (vs_edge) begin
                    overrun_set = 1'b1;
                    latch       = start_ok;
                    state_d     = start_ok ? ST_FIFO_RST : ST_IDLE;
                end else if (wd_inc == '1) begin
                    timeout_set = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (latch) begin
            out_x_res_d   = cfg_x_res - XW'(1);
            out_y_res_d   = cfg_y_res - YW'(1);
            out_nearest_d = ~cfg_mode;
            area_d        = AREA_W'(cfg_x_res) * AREA_W'(cfg_y_res);
            pix_cnt_d     = '0;
            wd_cnt_d      = '0;
            cnt_d         = '0;
        end

        fifo_rst_d    = (state_d == ST_FIFO_RST);
        busy_d        = (state_d != ST_IDLE);
        frame_done_d  = done;
        frame_cnt_d   = frame_cnt_q + 16'(done);
        err_overrun_d = overrun_set | (err_overrun_q & ~err_clr);
        err_timeout_d = timeout_set | (err_timeout_q & ~err_clr);
    end

    // State and output registers
    always_ff @(posedge clk_hdmi or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            pix_cnt_q      <= '0;
            area_q         <= '0;
            wd_cnt_q       <= '0;
            vsync_dly_q    <= 1'b0;
            out_x_res_q    <= '1;
            out_y_res_q    <= '1;
            out_nearest_q  <= DEF_NEAREST;
            fifo_rst_q     <= 1'b0;
            scaler_start_q <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            err_overrun_q  <= 1'b0;
            err_timeout_q  <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pix_cnt_q      <= pix_cnt_d;
            area_q         <= area_d;
            wd_cnt_q       <= wd_cnt_d;
            vsync_dly_q    <= vsync_in;
            out_x_res_q    <= out_x_res_d;
            out_y_res_q    <= out_y_res_d;
            out_nearest_q  <= out_nearest_d;
            fifo_rst_q     <= fifo_rst_d;
            scaler_start_q <= scaler_start_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
            err_overrun_q  <= err_overrun_d;
            err_timeout_q  <= err_timeout_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    assign fifo_rst     = fifo_rst_q;
    assign scaler_start = scaler_start_q;
    assign out_x_res    = out_x_res_q;
    assign out_y_res    = out_y_res_q;
    assign out_nearest  = out_nearest_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign err_overrun  = err_overrun_q;
    assign err_timeout  = err_timeout_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_scaler_frame_ctrl.sv
// Self-checking bench for scaler_frame_ctrl: frame table plus overrun, coincidence,
// timeout, idle-entry and async-reset sequences.
module tb_scaler_frame_ctrl;

    logic        clk_hdmi = 1'b0;
    logic        rst_n;
    logic        vsync_in;
    logic        cfg_enable;
    logic [10:0] cfg_x_res;
    logic [10:0] cfg_y_res;
    logic        cfg_mode;
    logic        dout_valid;
    logic        err_clr;
    logic        fifo_rst;
    logic        scaler_start;
    logic [10:0] out_x_res;
    logic [10:0] out_y_res;
    logic        out_nearest;
    logic        busy;
    logic        frame_done;
    logic        err_overrun;
    logic        err_timeout;
    logic [15:0] frame_cnt;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int fc_exp   = 0;

    typedef struct packed {
        logic [10:0] ox;
        logic [10:0] oy;
        logic        near;
    } shad_t;

    typedef struct {
        int x;
        int y;
        bit mode;
        bit gap;
        int npix;
        int ox;
        int oy;
        bit near;
    } vec_t;

    shad_t sb_q[$];
    vec_t  vecs[4];

    always #5 clk_hdmi = ~clk_hdmi;

    scaler_frame_ctrl #(
        .OUTPUT_X_RES_WIDTH(11),
        .OUTPUT_Y_RES_WIDTH(11),
        .RST_CYCLES(4),
        .SETTLE_CYCLES(1964),
        .TIMEOUT_WIDTH(6)
    ) dut (
        .clk_hdmi    (clk_hdmi),
        .rst_n       (rst_n),
        .vsync_in    (vsync_in),
        .cfg_enable  (cfg_enable),
        .cfg_x_res   (cfg_x_res),
        .cfg_y_res   (cfg_y_res),
        .cfg_mode    (cfg_mode),
        .dout_valid  (dout_valid),
        .err_clr     (err_clr),
        .fifo_rst    (fifo_rst),
        .scaler_start(scaler_start),
        .out_x_res   (out_x_res),
        .out_y_res   (out_y_res),
        .out_nearest (out_nearest),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout),
        .frame_cnt   (frame_cnt)
    );

    always @(negedge clk_hdmi) begin
        #1;
        if (rst_n === 1'b1 && frame_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pixels(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            dout_valid = 1'b1;
            @(negedge clk_hdmi);
            dout_valid = 1'b0;
            if (gap) @(negedge clk_hdmi);
        end
    endtask

    // Sync edge with new cfg, then follow fifo_rst and the start pulse; shadows checked at start.
    task automatic launch(input int x, input int y, input bit mode,
                          input int ox, input int oy, input bit near, input string tag);
        int    rst_hi;
        int    st_at;
        shad_t s;
        shad_t e;
        s.ox   = 11'(ox);
        s.oy   = 11'(oy);
        s.near = near;
        sb_q.push_back(s);
        cfg_enable = 1'b1;
        cfg_x_res  = 11'(x);
        cfg_y_res  = 11'(y);
        cfg_mode   = mode;
        vsync_in   = 1'b1;
        rst_hi     = 0;
        st_at      = 0;
        for (int k = 1; k <= 2500 && st_at == 0; k++) begin
            @(negedge clk_hdmi);
            if (k == 1) begin
                chk({tag, "_fifo_rst_latency"}, 32'(fifo_rst), 32'(1));
                vsync_in   = 1'b0;
                dout_valid = 1'b0;
            end
            if (fifo_rst === 1'b1) rst_hi++;
            if (scaler_start === 1'b1) st_at = k;
        end
        chk({tag, "_fifo_rst_cycles"}, 32'(rst_hi), 32'(4));
        chk({tag, "_start_cycle"}, 32'(st_at), 32'(1969));
        chk({tag, "_busy_run"}, 32'(busy), 32'(1));
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got empty queue expected entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_out_x_res"}, 32'(out_x_res), 32'(e.ox));
            chk({tag, "_out_y_res"}, 32'(out_y_res), 32'(e.oy));
            chk({tag, "_out_nearest"}, 32'(out_nearest), 32'(e.near));
        end
        @(negedge clk_hdmi);
        chk({tag, "_start_width"}, 32'(scaler_start), 32'(0));
    endtask

    task automatic finish_frame(input int n, input bit gap, input string tag);
        int d0;
        d0 = done_cnt;
        pixels(n - 1, gap);
        @(negedge clk_hdmi);
        chk({tag, "_no_early_done"}, 32'(done_cnt), 32'(d0));
        chk({tag, "_busy_before_last"}, 32'(busy), 32'(1));
        pixels(1, 1'b0);
        @(negedge clk_hdmi);
        fc_exp++;
        chk({tag, "_done_once"}, 32'(done_cnt), 32'(d0 + 1));
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(fc_exp));
        chk({tag, "_busy_after"}, 32'(busy), 32'(0));
        chk({tag, "_done_pulse_end"}, 32'(frame_done), 32'(0));
    endtask

    task automatic no_start(input int x, input int y, input bit en, input string tag);
        int rst_hi;
        int busy_hi;
        cfg_enable = en;
        cfg_x_res  = 11'(x);
        cfg_y_res  = 11'(y);
        vsync_in   = 1'b1;
        rst_hi     = 0;
        busy_hi    = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_hdmi);
            vsync_in = 1'b0;
            if (fifo_rst !== 1'b0) rst_hi++;
            if (busy !== 1'b0) busy_hi++;
        end
        chk({tag, "_no_fifo_rst"}, 32'(rst_hi), 32'(0));
        chk({tag, "_no_busy"}, 32'(busy_hi), 32'(0));
        chk({tag, "_no_overrun"}, 32'(err_overrun), 32'(0));
        cfg_enable = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_fifo_rst"}, 32'(fifo_rst), 32'(0));
        chk({tag, "_scaler_start"}, 32'(scaler_start), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_out_x_res"}, 32'(out_x_res), 32'h7FF);
        chk({tag, "_out_y_res"}, 32'(out_y_res), 32'h7FF);
        chk({tag, "_out_nearest"}, 32'(out_nearest), 32'(1));
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(0));
        chk({tag, "_errors"}, 32'({err_overrun, err_timeout, frame_done}), 32'(0));
    endtask

    initial begin
        int d0;
        vecs[0] = '{x: 4, y: 3, mode: 1'b1, gap: 1'b0, npix: 12, ox: 3, oy: 2, near: 1'b0};
        vecs[1] = '{x: 2, y: 2, mode: 1'b0, gap: 1'b1, npix: 4,  ox: 1, oy: 1, near: 1'b1};
        vecs[2] = '{x: 1, y: 1, mode: 1'b1, gap: 1'b0, npix: 1,  ox: 0, oy: 0, near: 1'b0};
        vecs[3] = '{x: 3, y: 5, mode: 1'b0, gap: 1'b1, npix: 15, ox: 2, oy: 4, near: 1'b1};

        rst_n      = 1'b0;
        vsync_in   = 1'b0;
        cfg_enable = 1'b1;
        cfg_x_res  = 11'd4;
        cfg_y_res  = 11'd3;
        cfg_mode   = 1'b1;
        dout_valid = 1'b0;
        err_clr    = 1'b0;
        repeat (3) @(negedge clk_hdmi);
        check_reset_values("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk_hdmi);
        check_reset_values("post_rst");

        for (int i = 0; i < 4; i++) begin
            launch(vecs[i].x, vecs[i].y, vecs[i].mode,
                   vecs[i].ox, vecs[i].oy, vecs[i].near, $sformatf("vec%0d", i));
            finish_frame(vecs[i].npix, vecs[i].gap, $sformatf("vec%0d", i));
        end

        // Mid-frame cfg change must not reach the shadows until the next frame.
        launch(4, 3, 1'b1, 3, 2, 1'b0, "cfgchg_a");
        cfg_x_res = 11'd8;
        @(negedge clk_hdmi);
        chk("cfgchg_hold_run", 32'(out_x_res), 32'(3));
        finish_frame(12, 1'b0, "cfgchg_a");
        chk("cfgchg_hold_idle", 32'(out_x_res), 32'(3));
        launch(8, 3, 1'b1, 7, 2, 1'b0, "cfgchg_b");
        finish_frame(24, 1'b0, "cfgchg_b");

        // Early sync edge after 5 of 12 pixels.
        launch(4, 3, 1'b1, 3, 2, 1'b0, "ov1");
        d0 = done_cnt;
        pixels(5, 1'b0);
        launch(4, 3, 1'b1, 3, 2, 1'b0, "ov2");
        chk("ov_err_overrun", 32'(err_overrun), 32'(1));
        chk("ov_no_done", 32'(done_cnt), 32'(d0));
        chk("ov_frame_cnt", 32'(frame_cnt), 32'(fc_exp));
        finish_frame(12, 1'b0, "ov2");
        chk("ov_sticky", 32'(err_overrun), 32'(1));
        err_clr = 1'b1;
        @(negedge clk_hdmi);
        err_clr = 1'b0;
        chk("ov_clr", 32'(err_overrun), 32'(0));

        // Sync edge on the final pixel: frame completes and the next one starts, no overrun.
        launch(2, 1, 1'b1, 1, 0, 1'b0, "co1");
        d0 = done_cnt;
        pixels(1, 1'b0);
        dout_valid = 1'b1;
        launch(3, 1, 1'b0, 2, 0, 1'b1, "co2");
        fc_exp++;
        chk("co_done", 32'(done_cnt), 32'(d0 + 1));
        chk("co_frame_cnt", 32'(frame_cnt), 32'(fc_exp));
        chk("co_no_overrun", 32'(err_overrun), 32'(0));
        finish_frame(3, 1'b0, "co2");

        no_start(0, 3, 1'b1, "zero_x");
        no_start(4, 0, 1'b1, "zero_y");
        no_start(4, 3, 1'b0, "disabled");

        // Watchdog with no output pixels.
        launch(2, 2, 1'b0, 1, 1, 1'b1, "to");
        d0 = done_cnt;
        repeat (58) @(negedge clk_hdmi);
        chk("to_not_early", 32'(err_timeout), 32'(0));
        chk("to_busy_early", 32'(busy), 32'(1));
        repeat (7) @(negedge clk_hdmi);
        chk("to_err_timeout", 32'(err_timeout), 32'(1));
        chk("to_idle", 32'(busy), 32'(0));
        chk("to_no_done", 32'(done_cnt), 32'(d0));
        chk("to_frame_cnt", 32'(frame_cnt), 32'(fc_exp));
        err_clr = 1'b1;
        @(negedge clk_hdmi);
        err_clr = 1'b0;
        chk("to_clr", 32'(err_timeout), 32'(0));

        // Asynchronous reset while settling.
        cfg_x_res = 11'd4;
        cfg_y_res = 11'd3;
        cfg_mode  = 1'b1;
        vsync_in  = 1'b1;
        @(negedge clk_hdmi);
        vsync_in = 1'b0;
        repeat (20) @(negedge clk_hdmi);
        chk("ar_busy_settle", 32'(busy), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("ar");
        @(negedge clk_hdmi);
        rst_n  = 1'b1;
        fc_exp = 0;
        repeat (5) @(negedge clk_hdmi);
        chk("ar_stay_idle", 32'(busy), 32'(0));
        launch(4, 3, 1'b1, 3, 2, 1'b0, "ar_recover");
        finish_frame(12, 1'b0, "ar_recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
